// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    // Sequencer states; 3'b111 is unused and recovers to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_EVAL  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_STORE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Shift-register mode {sr_c1, sr_c0}; 2'b10 is never driven.
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SHR  = 2'b01;
    localparam logic [1:0] SR_LOAD = 2'b11;

    // ALU op {alu_c2, alu_c1, alu_c0}; only these two codes are used.
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;

    // Control word layout (13 datapath control lines).
    localparam int CW_W      = 13;
    localparam int CW_CLRACC = 0;
    localparam int CW_ENACC  = 1;
    localparam int CW_ALU    = 2;   // 3 bits: [4:2] = {alu_c2, alu_c1, alu_c0}
    localparam int CW_SRSEL  = 5;
    localparam int CW_ENSR   = 6;
    localparam int CW_SR     = 7;   // 2 bits: [8:7] = {sr_c1, sr_c0}
    localparam int CW_ABSEL  = 9;
    localparam int CW_ENDPO  = 10;
    localparam int CW_ENB    = 11;
    localparam int CW_ENA    = 12;

endpackage

// File: rtl/mult_ctrl_decode.sv
// Decodes sequencer state (plus multiplier LSB in EVAL) into the datapath control word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the datapath always accepts its control lines.
module mult_ctrl_decode
    import mult_pkg::*;
(
    input  logic [2:0]      st,
    input  logic            flag,
    output logic [CW_W-1:0] cw
);

    // Per-state control lines; unknown encodings leave every line inactive.
    always_comb begin
        cw = '0;
        case (st)
            ST_LOAD: begin
                cw[CW_ENA]          = 1'b1;
                cw[CW_ENB]          = 1'b1;
                cw[CW_ENSR]         = 1'b1;
                cw[CW_SR +: 2]      = SR_LOAD;
                cw[CW_SRSEL]        = 1'b0;   // SR takes operand B
            end
            ST_CLEAR: begin
                cw[CW_CLRACC]       = 1'b1;
            end
            ST_EVAL: begin
                // Only Mealy term: add A when the current multiplier bit is set.
                cw[CW_ENACC]        = 1'b1;
                cw[CW_ALU +: 3]     = flag ? ALU_ADD : ALU_PASS;
            end
            ST_SHIFT: begin
                // ACC and SR shift right together; ACC LSB feeds the SR MSB.
                cw[CW_ENSR]         = 1'b1;
                cw[CW_SR +: 2]      = SR_SHR;
                cw[CW_SRSEL]        = 1'b1;
                cw[CW_ENACC]        = 1'b1;
                cw[CW_ALU +: 3]     = ALU_PASS;
            end
            ST_STORE: begin
                cw[CW_ABSEL]        = 1'b1;
                cw[CW_ENDPO]        = 1'b1;
            end
            default: begin
                cw = '0;
            end
        endcase
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier: load, N eval/shift iterations, store, done pulse.
// Latency: fixed 2N+4 cycles from start sampled in IDLE to the done pulse.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic start,
    input  logic flag,
    output logic busy,
    output logic done,
    output logic enA,
    output logic enB,
    output logic enDPO,
    output logic ABsel,
    output logic sr_c1,
    output logic sr_c0,
    output logic enSR,
    output logic SRsel,
    output logic alu_c2,
    output logic alu_c1,
    output logic alu_c0,
    output logic enACC,
    output logic clrACC
);

    localparam int               CNT_W    = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CW_W-1:0]  cw;

    // State and iteration counter registers; reset wins over everything.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, next-count and status outputs decoded from the state register.
    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = start ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                cnt_d   = '0;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                busy    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_STORE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_STORE: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mult_ctrl_decode u_decode (
        .st   (state_q),
        .flag (flag),
        .cw   (cw)
    );

    assign enA    = cw[CW_ENA];
    assign enB    = cw[CW_ENB];
    assign enDPO  = cw[CW_ENDPO];
    assign ABsel  = cw[CW_ABSEL];
    assign sr_c1  = cw[CW_SR + 1];
    assign sr_c0  = cw[CW_SR];
    assign enSR   = cw[CW_ENSR];
    assign SRsel  = cw[CW_SRSEL];
    assign alu_c2 = cw[CW_ALU + 2];
    assign alu_c1 = cw[CW_ALU + 1];
    assign alu_c0 = cw[CW_ALU];
    assign enACC  = cw[CW_ENACC];
    assign clrACC = cw[CW_CLRACC];

endmodule
